// File: rtl/debounce_pkg.sv
// Shared types and default constants for the input debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        CHK_HIGH = 2'd1,
        ST_HIGH  = 2'd2,
        CHK_LOW  = 2'd3
    } deb_state_t;

    localparam int unsigned DEB_SYNC_STAGES_DEF   = 2;
    localparam int unsigned DEB_STABLE_CYCLES_DEF = 4;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchronizer bringing a raw asynchronous bit into the clk domain.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic s_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw input through the chain; every stage clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input: synchronizer, stability-counting FSM,
// registered clean level and optional single-cycle rise/fall strobes.
// Build option: define INPUT_DEBOUNCER_EDGE_EN to compile in the strobe
// registers; otherwise rise/fall are tied low.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
    parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (d),
        .s_o  (s)
    );

    // State, stability counter and clean level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    // Next state: a level change must persist STABLE_CYCLES samples to commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        case (state_q)
            ST_LOW: begin
                if (s) begin
                    state_d = CHK_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_HIGH: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    q_d     = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    state_d = CHK_LOW;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    q_d     = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                q_d     = 1'b0;
            end
        endcase
    end

    assign q = q_q;

`ifdef INPUT_DEBOUNCER_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Strobe fires on the same edge that commits the new level of q.
    always_comb begin
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (q_d && !q_q) begin
            rise_d = 1'b1;
        end
        if (!q_d && q_q) begin
            fall_d = 1'b1;
        end
    end

    // Strobe registers; cleared by reset so an aborted check emits nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer: two instances (default and
// SYNC_STAGES=3/STABLE_CYCLES=2) driven by the same stimulus and compared
// against a run-length reference model.
module tb_input_debouncer;

    localparam int unsigned S0 = 2;
    localparam int unsigned T0 = 4;
    localparam int unsigned S1 = 3;
    localparam int unsigned T1 = 2;

`ifdef INPUT_DEBOUNCER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic d;
    logic q0, r0, f0;
    logic q1, r1, f1;
    logic [2:0] obs [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic hist [$];
    int   m_run  [2];
    logic m_q    [2];
    logic m_rise [2];
    logic m_fall [2];
    int   sync_n [2];
    int   stab_n [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    input_debouncer #(.SYNC_STAGES(S0), .STABLE_CYCLES(T0)) dut0 (
        .clk(clk), .rst_n(rst_n), .d(d), .q(q0), .rise(r0), .fall(f0)
    );
    input_debouncer #(.SYNC_STAGES(S1), .STABLE_CYCLES(T1)) dut1 (
        .clk(clk), .rst_n(rst_n), .d(d), .q(q1), .rise(r1), .fall(f1)
    );

    assign obs[0] = {q0, r0, f0};
    assign obs[1] = {q1, r1, f1};

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 2; i++) begin
            m_run[i]  = 0;
            m_q[i]    = 1'b0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
        end
    endfunction

    // The level seen after the synchronizer at edge n is the d captured SYNC
    // edges earlier; q flips once STABLE consecutive seen samples differ from it.
    function automatic void model_edge(input logic dv);
        int   n;
        logic s;
        n = hist.size();
        for (int i = 0; i < 2; i++) begin
            s = (n >= sync_n[i]) ? hist[n - sync_n[i]] : 1'b0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (s != m_q[i]) m_run[i] = m_run[i] + 1;
            else             m_run[i] = 0;
            if (m_run[i] == stab_n[i]) begin
                m_q[i]   = s;
                m_run[i] = 0;
                m_rise[i] = EDGE_EN & s;
                m_fall[i] = EDGE_EN & ~s;
            end
        end
        hist.push_back(dv);
    endfunction

    task automatic cycle(input logic dv);
        d = dv;
        @(posedge clk);
        if (rst_n) model_edge(dv);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        cycle(1'b0);
        cycle(1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int hi0, hi1;
        hi0 = -1;
        hi1 = -1;
        rst_n = 1'b0;
        d = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if ({q0, r0, f0, q1, r1, f1} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_init outputs got %b exp 000000", {q0, r0, f0, q1, r1, f1});
        end
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== {m_q[i], m_rise[i], m_fall[i]}) begin
                    n_fail++;
                    $display("FAIL reset_hold inst%0d c%0d q/rise/fall got %b exp %b", i, c, obs[i], {m_q[i], m_rise[i], m_fall[i]});
                end
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== {m_q[i], m_rise[i], m_fall[i]}) begin
                    n_fail++;
                    $display("FAIL reset_release inst%0d c%0d q/rise/fall got %b exp %b", i, c, obs[i], {m_q[i], m_rise[i], m_fall[i]});
                end
            end
            if (q0 && hi0 < 0) hi0 = c;
            if (q1 && hi1 < 0) hi1 = c;
        end
        n_tests++;
        if (hi0 !== 5) begin
            n_fail++;
            $display("FAIL reset_latency0 q rise edge got %0d exp 5", hi0);
        end
        n_tests++;
        if (hi1 !== 4) begin
            n_fail++;
            $display("FAIL reset_latency1 q rise edge got %0d exp 4", hi1);
        end
        // Asynchronous assertion clears q without waiting for a clock edge.
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({q0, r0, f0, q1, r1, f1} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_async outputs got %b exp 000000", {q0, r0, f0, q1, r1, f1});
        end
    endtask

    task automatic test_clean_step();
        int hi, rc, rat, lo, fc, fat;
        hi = -1; rc = 0; rat = -1;
        lo = -1; fc = 0; fat = -1;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== {m_q[i], m_rise[i], m_fall[i]}) begin
                    n_fail++;
                    $display("FAIL step_up inst%0d c%0d q/rise/fall got %b exp %b", i, c, obs[i], {m_q[i], m_rise[i], m_fall[i]});
                end
            end
            if (q0 && hi < 0) hi = c;
            if (r0) begin rc++; rat = c; end
        end
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== {m_q[i], m_rise[i], m_fall[i]}) begin
                    n_fail++;
                    $display("FAIL step_down inst%0d c%0d q/rise/fall got %b exp %b", i, c, obs[i], {m_q[i], m_rise[i], m_fall[i]});
                end
            end
            if (!q0 && lo < 0) lo = c;
            if (f0) begin fc++; fat = c; end
        end
        n_tests++;
        if (hi !== 5) begin n_fail++; $display("FAIL step_q_rise edge got %0d exp 5", hi); end
        n_tests++;
        if (rc !== (EDGE_EN ? 1 : 0) || rat !== (EDGE_EN ? 5 : -1)) begin
            n_fail++;
            $display("FAIL step_rise count/edge got %0d/%0d exp %0d/%0d", rc, rat, EDGE_EN ? 1 : 0, EDGE_EN ? 5 : -1);
        end
        n_tests++;
        if (lo !== 5) begin n_fail++; $display("FAIL step_q_fall edge got %0d exp 5", lo); end
        n_tests++;
        if (fc !== (EDGE_EN ? 1 : 0) || fat !== (EDGE_EN ? 5 : -1)) begin
            n_fail++;
            $display("FAIL step_fall count/edge got %0d/%0d exp %0d/%0d", fc, fat, EDGE_EN ? 1 : 0, EDGE_EN ? 5 : -1);
        end
    endtask

    task automatic test_glitch();
        int seen_q, seen_r;
        seen_q = 0;
        seen_r = 0;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            cycle(c < 3);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== {m_q[i], m_rise[i], m_fall[i]}) begin
                    n_fail++;
                    $display("FAIL glitch inst%0d c%0d q/rise/fall got %b exp %b", i, c, obs[i], {m_q[i], m_rise[i], m_fall[i]});
                end
            end
            if (q0) seen_q++;
            if (r0) seen_r++;
        end
        n_tests++;
        if (seen_q !== 0 || seen_r !== 0) begin
            n_fail++;
            $display("FAIL glitch_reject q-high/rise cycles got %0d/%0d exp 0/0", seen_q, seen_r);
        end
    endtask

    task automatic test_chatter();
        int strobes, hi, rc, rat;
        strobes = 0; hi = -1; rc = 0; rat = -1;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cycle((c % 2) == 0);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== {m_q[i], m_rise[i], m_fall[i]}) begin
                    n_fail++;
                    $display("FAIL chatter inst%0d c%0d q/rise/fall got %b exp %b", i, c, obs[i], {m_q[i], m_rise[i], m_fall[i]});
                end
            end
            if (r0 | f0 | r1 | f1 | q0 | q1) strobes++;
        end
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== {m_q[i], m_rise[i], m_fall[i]}) begin
                    n_fail++;
                    $display("FAIL settle inst%0d c%0d q/rise/fall got %b exp %b", i, c, obs[i], {m_q[i], m_rise[i], m_fall[i]});
                end
            end
            if (q0 && hi < 0) hi = c;
            if (r0) begin rc++; rat = c; end
        end
        n_tests++;
        if (strobes !== 0) begin
            n_fail++;
            $display("FAIL chatter_quiet active cycles got %0d exp 0", strobes);
        end
        n_tests++;
        if (hi !== 5 || rc !== (EDGE_EN ? 1 : 0) || rat !== (EDGE_EN ? 5 : -1)) begin
            n_fail++;
            $display("FAIL settle_rise q-edge/count/edge got %0d/%0d/%0d exp 5/%0d/%0d", hi, rc, rat, EDGE_EN ? 1 : 0, EDGE_EN ? 5 : -1);
        end
    endtask

    task automatic test_reset_mid_check();
        int hi, rc;
        hi = -1; rc = 0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cycle(1'b1);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== {m_q[i], m_rise[i], m_fall[i]}) begin
                    n_fail++;
                    $display("FAIL midchk_pre inst%0d c%0d q/rise/fall got %b exp %b", i, c, obs[i], {m_q[i], m_rise[i], m_fall[i]});
                end
            end
            if (r0) rc++;
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({q0, r0, f0} !== 3'b000) begin
            n_fail++;
            $display("FAIL midchk_async inst0 q/rise/fall got %b exp 000", {q0, r0, f0});
        end
        cycle(1'b1);
        cycle(1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1);
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (obs[i] !== {m_q[i], m_rise[i], m_fall[i]}) begin
                    n_fail++;
                    $display("FAIL midchk_post inst%0d c%0d q/rise/fall got %b exp %b", i, c, obs[i], {m_q[i], m_rise[i], m_fall[i]});
                end
            end
            if (q0 && hi < 0) hi = c;
            if (r0) rc++;
        end
        n_tests++;
        if (hi !== 5 || rc !== (EDGE_EN ? 1 : 0)) begin
            n_fail++;
            $display("FAIL midchk_relatency q-edge/rise-count got %0d/%0d exp 5/%0d", hi, rc, EDGE_EN ? 1 : 0);
        end
    endtask

    task automatic test_random();
        int   c, last0, bad_sp, both;
        logic v;
        int   len;
        c = 0; last0 = -1000; bad_sp = 0; both = 0;
        do_reset();
        while (c < 400) begin
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            for (int k = 0; k < len; k++) begin
                cycle(v);
                for (int i = 0; i < 2; i++) begin
                    n_tests++;
                    if (obs[i] !== {m_q[i], m_rise[i], m_fall[i]}) begin
                        n_fail++;
                        $display("FAIL random inst%0d c%0d q/rise/fall got %b exp %b", i, c, obs[i], {m_q[i], m_rise[i], m_fall[i]});
                    end
                end
                if ((r0 & f0) | (r1 & f1)) both++;
                if (r0 | f0) begin
                    if (c - last0 < int'(T0)) bad_sp++;
                    last0 = c;
                end
                c++;
            end
        end
        n_tests++;
        if (both !== 0 || bad_sp !== 0) begin
            n_fail++;
            $display("FAIL random_strobe_rules both-high/short-spacing got %0d/%0d exp 0/0", both, bad_sp);
        end
    endtask

    initial begin
        sync_n[0] = int'(S0);
        sync_n[1] = int'(S1);
        stab_n[0] = int'(T0);
        stab_n[1] = int'(T1);
        rst_n = 1'b0;
        d     = 1'b0;
        model_reset();
        test_reset();
        test_clean_step();
        test_glitch();
        test_chatter();
        test_reset_mid_check();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions a raw, asynchronous single-bit input before it reaches the d-input of the team's storage flip-flops. Synchronizes the input into the `clk` domain and filters it with a stability counter. Publishes a clean level `q` and, optionally, single-cycle rise/fall strobes. Sits directly upstream of d_flipflop-style registers and counters.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth; legal ≥ 2.
- `STABLE_CYCLES`, default 4: consecutive synchronized samples at the new level required before `q` changes; legal ≥ 2.
- `clk`  input  1  single clock; all state updates on posedge.
- `rst_n`  input  1  reset, asynchronous and active-low: asserts immediately, releases on a posedge.
- `d`  input  1  raw input, asynchronous to `clk`.
- `q`  output  1  debounced level, registered.
- `rise`  output  1  one-cycle strobe on a 0→1 change of `q`.
- `fall`  output  1  one-cycle strobe on a 1→0 change of `q`.

## Operation
- Synchronizer: `SYNC_STAGES` flops in series; the last stage is `s`. All stages reset to 0.
- Counter: `cnt`, width `$clog2(STABLE_CYCLES)`, reset 0.
- FSM states: `ST_LOW`, `CHK_HIGH`, `ST_HIGH`, `CHK_LOW`. Reset state is `ST_LOW`.
- `ST_LOW`:
  - `s`=1 → `CHK_HIGH`, `cnt`←1.
  - Otherwise hold.
- `CHK_HIGH`:
  - `s`=0 → `ST_LOW`, `cnt`←0. This is a glitch; `q` is unchanged.
  - `s`=1 and `cnt`==`STABLE_CYCLES`-1 → `ST_HIGH`, `q`←1, `cnt`←0.
  - Otherwise `cnt`←`cnt`+1.
- `ST_HIGH` and `CHK_LOW` mirror `ST_LOW` and `CHK_HIGH` with polarity inverted.
- `q` is 1 exactly in `ST_HIGH` and `CHK_LOW`.
- `cnt` never exceeds `STABLE_CYCLES`-1. No wrap-around is possible.
- Reset values: `q`=0, `rise`=0, `fall`=0, `cnt`=0, FSM in `ST_LOW`.
- Reset asserted mid-check discards all progress; no strobe is emitted.

## Timing
- Edge k is the first posedge at which sync stage 1 captures the new `d` level.
- `q` updates at edge k+`SYNC_STAGES`+`STABLE_CYCLES`-1. With defaults this is edge k+5.
- A pulse on `d` shorter than `STABLE_CYCLES` cycles (as seen at `s`) never changes `q`.
- `rise`/`fall` assert on the same edge as the `q` change and deassert on the next edge. They are registered, never combinational.
- `rise` and `fall` are never high together.
- After `rst_n` releases, the minimum spacing between consecutive strobes is `STABLE_CYCLES` cycles.
- Behaviour is fully defined even if `d` toggles every cycle: `q` holds.

## Configuration
- Macro: `INPUT_DEBOUNCER_EDGE_EN`.
- Defined: edge-strobe logic is compiled in; `rise` and `fall` behave as above.
- Undefined: no strobe registers exist; `rise` and `fall` are tied to constant 0. `q` behaviour is identical in both builds.

## Structure
- Package `debounce_pkg`:
  - `typedef enum logic [1:0] {ST_LOW, CHK_HIGH, ST_HIGH, CHK_LOW} deb_state_t`.
  - Default-parameter constants `DEB_SYNC_STAGES_DEF`=2 and `DEB_STABLE_CYCLES_DEF`=4.
- Sub-module `sync_chain`: parameterised `SYNC_STAGES`-deep synchronizer with `clk`/`rst_n` reset to 0. It is instantiated once. The FSM, counter and strobes stay in the top module.

## Test plan
- Reset: hold `rst_n`=0 with `d`=1, then release → `q`=0, `rise`=0 and `fall`=0 during reset. `q` goes to 1 exactly 5 edges after the first capture.
- Clean step, defaults: `d` 0→1 held 10 cycles → `q`=1 at edge k+5, `rise` high for exactly that one cycle. `d` 1→0 → `fall` high for one cycle, `q`=0 at edge k'+5.
- Glitch rejection: `d`=1 for 3 cycles, then 0 → `q` stays 0, `rise` never asserts, FSM returns to `ST_LOW`.
- Chatter: `d` toggles every cycle for 20 cycles, then settles at 1 → no strobes during the chatter. A single `rise` occurs 5 edges after settling.
- Reset mid-check: drop `rst_n` while in `CHK_HIGH` with `cnt`=2 → `q`=0 immediately, no `rise`. After release, the input requires the full latency again.
- Macro off, with `STABLE_CYCLES`=2 and `SYNC_STAGES`=3: step `d` → `q` changes at edge k+4, `rise` and `fall` stay 0 throughout.
